// File: rtl/nukv_predicate_packer_pkg.sv
// Shared constants, state encoding and slot layout helper for the predicate packer.
package nukv_predicate_packer_pkg;

  localparam int unsigned PRED_W = 48;
  localparam int unsigned LEN_W  = 16;
  localparam logic [PRED_W-1:0] NOP_PRED = 48'h0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_EMIT    = 2'd3
  } state_t;

  // Bit offset of predicate slot k inside the packed word.
  function automatic int unsigned slot_offset(input int unsigned meta_w, input int unsigned k);
    return meta_w + LEN_W + k * PRED_W;
  endfunction

endpackage

// File: rtl/nukv_predicate_packer_if.sv
// Header, entry and packed-word handshakes between decoder, packer and predicate pipeline.
interface nukv_predicate_packer_if #(
  parameter int unsigned META_WIDTH   = 96,
  parameter int unsigned MEMORY_WIDTH = 512
) ();
  logic                               req_valid;
  logic                               req_ready;
  logic [META_WIDTH-1:0]              req_meta;
  logic [15:0]                        req_length;
  logic [3:0]                         req_npreds;
  logic                               req_scan;

  logic                               ent_valid;
  logic                               ent_ready;
  logic [47:0]                        ent_data;
  logic                               ent_last;

  logic [META_WIDTH+MEMORY_WIDTH-1:0] pred_data;
  logic                               pred_valid;
  logic                               pred_scan;
  logic                               pred_ready;

  modport master (
    output req_valid, req_meta, req_length, req_npreds, req_scan,
    output ent_valid, ent_data, ent_last,
    output pred_ready,
    input  req_ready, ent_ready, pred_data, pred_valid, pred_scan
  );

  modport slave (
    input  req_valid, req_meta, req_length, req_npreds, req_scan,
    input  ent_valid, ent_data, ent_last,
    input  pred_ready,
    output req_ready, ent_ready, pred_data, pred_valid, pred_scan
  );
endinterface

// File: rtl/nukv_predicate_slot_reg.sv
// Predicate slot register bank: clear-to-NOP, write-at-index and pad-from-index.
module nukv_predicate_slot_reg
  import nukv_predicate_packer_pkg::*;
#(
  parameter int unsigned MAX_PREDS = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [3:0]                    wr_idx,
  input  logic [PRED_W-1:0]             wr_data,
  input  logic                          pad_en,
  input  logic [3:0]                    pad_idx,
  output logic [MAX_PREDS*PRED_W-1:0]   slots
);

  logic [PRED_W-1:0] slot_q [MAX_PREDS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < MAX_PREDS; k++) slot_q[k] <= NOP_PRED;
    end else if (clear) begin
      for (int unsigned k = 0; k < MAX_PREDS; k++) slot_q[k] <= NOP_PRED;
    end else begin
      // pad_idx is always above wr_idx, so write and pad never target the same slot
      for (int unsigned k = 0; k < MAX_PREDS; k++) begin
        if (wr_en && wr_idx == 4'(k))
          slot_q[k] <= wr_data;
        else if (pad_en && 4'(k) >= pad_idx)
          slot_q[k] <= NOP_PRED;
      end
    end
  end

  always_comb begin
    slots = '0;
    for (int unsigned k = 0; k < MAX_PREDS; k++) slots[k*PRED_W +: PRED_W] = slot_q[k];
  end

endmodule

// File: rtl/nukv_predicate_packer.sv
// Packs a request header and its predicate entries into one wide predicate-configuration word.
module nukv_predicate_packer
  import nukv_predicate_packer_pkg::*;
#(
  parameter int unsigned MEMORY_WIDTH = 512,
  parameter int unsigned META_WIDTH   = 96,
  parameter int unsigned MAX_PREDS    = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  nukv_predicate_packer_if.slave  bus,
  output logic                    error_count,
  output logic [31:0]             words_out
);

  localparam int unsigned WORD_W = META_WIDTH + MEMORY_WIDTH;

  state_t                       state;
  logic [META_WIDTH-1:0]        meta_q;
  logic [LEN_W-1:0]             len_q;
  logic [3:0]                   target;
  logic [3:0]                   slot_cnt;
  logic [3:0]                   nxt_cnt;
  logic                         err_flagged;
  logic                         pred_valid_q;
  logic                         pred_scan_q;
  logic [MAX_PREDS*PRED_W-1:0]  slots;
  logic [WORD_W-1:0]            word;

  logic req_fire;
  logic ent_fire;
  logic short_last;

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.ent_ready = (state == ST_COLLECT) || (state == ST_DRAIN);

  assign req_fire   = (state == ST_IDLE) && bus.req_valid;
  assign ent_fire   = (state == ST_COLLECT) && bus.ent_valid;
  assign nxt_cnt    = slot_cnt + 4'd1;
  assign short_last = ent_fire && bus.ent_last && (nxt_cnt < target);

  nukv_predicate_slot_reg #(
    .MAX_PREDS (MAX_PREDS)
  ) u_slots (
    .clk     (clk),
    .rst     (rst),
    .clear   (req_fire),
    .wr_en   (ent_fire),
    .wr_idx  (slot_cnt),
    .wr_data (bus.ent_data),
    .pad_en  (short_last),
    .pad_idx (nxt_cnt),
    .slots   (slots)
  );

  // The word is pure wiring of registers that only change outside EMIT, so it holds under backpressure.
  always_comb begin
    word = '0;
    word[META_WIDTH-1:0]         = meta_q;
    word[META_WIDTH +: LEN_W]    = len_q;
    for (int unsigned k = 0; k < MAX_PREDS; k++)
      word[slot_offset(META_WIDTH, k) +: PRED_W] = slots[k*PRED_W +: PRED_W];
  end

  assign bus.pred_data  = word;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_scan  = pred_scan_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      meta_q       <= '0;
      len_q        <= '0;
      target       <= '0;
      slot_cnt     <= '0;
      err_flagged  <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_scan_q  <= 1'b0;
      error_count  <= 1'b0;
      words_out    <= '0;
    end else begin
      error_count <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            meta_q      <= bus.req_meta;
            len_q       <= bus.req_length;
            pred_scan_q <= bus.req_scan;
            slot_cnt    <= '0;
            if (bus.req_npreds > 4'(MAX_PREDS)) begin
              target      <= 4'(MAX_PREDS);
              err_flagged <= 1'b1;
              error_count <= 1'b1;
            end else begin
              target      <= bus.req_npreds;
              err_flagged <= 1'b0;
            end
            if (bus.req_npreds == 4'd0) begin
              state        <= ST_EMIT;
              pred_valid_q <= 1'b1;
            end else begin
              state <= ST_COLLECT;
            end
          end
        end

        ST_COLLECT: begin
          if (bus.ent_valid) begin
            slot_cnt <= nxt_cnt;
            if (nxt_cnt == target) begin
              if (bus.ent_last) begin
                state        <= ST_EMIT;
                pred_valid_q <= 1'b1;
              end else begin
                state <= ST_DRAIN;
              end
            end else if (bus.ent_last) begin
              // Short list; an over-limit header may already have used this request's pulse
              error_count  <= !err_flagged;
              err_flagged  <= 1'b1;
              state        <= ST_EMIT;
              pred_valid_q <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (bus.ent_valid && bus.ent_last) begin
            error_count  <= !err_flagged;
            err_flagged  <= 1'b1;
            state        <= ST_EMIT;
            pred_valid_q <= 1'b1;
          end
        end

        ST_EMIT: begin
          if (bus.pred_ready) begin
            pred_valid_q <= 1'b0;
            words_out    <= words_out + 32'd1;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
